// File: rtl/rca_serial_ctrl_pkg.sv
// rca_serial_ctrl_pkg
//   Types and constants shared by the nibble-serial add/subtract sequencer
//   and its ripple-carry slice.
//   - SLICE_W     : width of the shared adder slice (one nibble).
//   - state_t     : sequencer states IDLE / RUN / DONE.
//   - slice_count : number of slice passes needed for a given operand width.
package rca_serial_ctrl_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int slice_count(input int width);
    return width / SLICE_W;
  endfunction

endpackage

// File: rtl/full_adder.sv
// full_adder
//   Single-bit full adder cell.
//   Ports: a, b, cin (inputs); s (sum), cout (carry out).
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/rca_slice4.sv
// rca_slice4
//   Purely combinational 4-bit ripple-carry adder built from four
//   full_adder cells.
//   Ports: a[3:0], b[3:0], cin (inputs); s[3:0] (sum), cout (carry out).
module rca_slice4
  import rca_serial_ctrl_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] s,
  output logic               cout
);

  logic [SLICE_W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < SLICE_W; i++) begin : g_bit
    full_adder u_fa (
      .a   (a[i]),
      .b   (b[i]),
      .cin (c[i]),
      .s   (s[i]),
      .cout(c[i+1])
    );
  end

  assign cout = c[SLICE_W];

endmodule

// File: rtl/rca_serial_ctrl.sv
// rca_serial_ctrl
//   WIDTH-bit add/subtract performed one nibble per clock through a single
//   shared 4-bit ripple-carry slice, LSB nibble first.
//   Ports:
//     clk, rst_n   : rising-edge clock, asynchronous active-low reset.
//     start        : request an operation (accepted in IDLE or DONE).
//     sub          : 0 = A+B, 1 = A-B; sampled with start.
//     A, B         : operands, sampled with start.
//     busy         : high while nibbles are being processed.
//     done         : one-cycle pulse when Q/ovf are updated.
//     Q            : {carry_out, sum}, held until the next result.
//     ovf          : signed overflow of the last operation.
module rca_serial_ctrl
  import rca_serial_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   Q,
  output logic             ovf
);

  localparam int NSLICE = slice_count(WIDTH);
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  if (WIDTH < SLICE_W || (WIDTH % SLICE_W) != 0) begin : g_bad_width
    $error("rca_serial_ctrl: WIDTH must be a multiple of 4 and at least 4");
  end

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             carry_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;   // already inverted for subtraction
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;

  logic [SLICE_W-1:0] s_a;
  logic [SLICE_W-1:0] s_b;
  logic [SLICE_W-1:0] s_sum;
  logic               s_cout;

  rca_slice4 u_slice (
    .a   (s_a),
    .b   (s_b),
    .cin (carry_r),
    .s   (s_sum),
    .cout(s_cout)
  );

  // Route the current nibble into the slice and splice its sum back into
  // the accumulator, so the final edge can publish the complete result.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    s_a      = a_r[idx*SLICE_W +: SLICE_W];
    s_b      = b_r[idx*SLICE_W +: SLICE_W];
    acc_next = acc;
    acc_next[idx*SLICE_W +: SLICE_W] = s_sum;
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      carry_r <= 1'b0;
      a_r     <= '0;
      b_r     <= '0;
      acc     <= '0;
      Q       <= '0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_r     <= A;
            b_r     <= sub ? ~B : B;
            carry_r <= sub;   // +1 completes the two's complement of B
            idx     <= '0;
            state   <= RUN;
          end else begin
            state   <= IDLE;
          end
        end
        RUN: begin
          acc     <= acc_next;
          carry_r <= s_cout;
          idx     <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            Q     <= {s_cout, acc_next};
            ovf   <= (a_r[WIDTH-1] == b_r[WIDTH-1]) &&
                     (acc_next[WIDTH-1] != a_r[WIDTH-1]);
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/rca_serial_ctrl.md
Name: rca_serial_ctrl

Overview:
- Sequencer that performs a WIDTH-bit add or subtract by time-multiplexing one 4-bit ripple-carry adder slice, one nibble per clock, LSB nibble first.
- Uses a start/busy/done handshake and holds the result until the next operation.
- Sits between the operand source (switch/register logic) and the display/result register, so a single small adder serves wide operands.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of 4 and at least 4 (elaboration error otherwise).
- NSLICE, WIDTH/4, derived number of nibble passes; not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a new operation; sampled on rising clk.
- sub  input  1  0 = A+B, 1 = A-B; sampled with start.
- A  input  WIDTH  operand A; sampled with start.
- B  input  WIDTH  operand B; sampled with start.
- busy  output  1  high while slices are being processed.
- done  output  1  one-cycle pulse when Q/ovf become valid.
- Q  output  WIDTH+1  {carry_out, sum}; held between operations.
- ovf  output  1  signed two's-complement overflow of the last operation.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy=0, done=0, Q=0, ovf=0; slice index, carry and operand/accumulator registers cleared.
- Reset mid-operation aborts the operation. No done is issued. Q stays 0 after release.
- States:
  - IDLE: busy=0, done=0.
  - RUN: busy=1.
  - DONE: done=1, busy=0.
- Start acceptance: start is accepted on an edge where state is IDLE or DONE; this allows back-to-back operations. On acceptance:
  - latch A into a_r.
  - latch B into b_r, stored as ~B when sub=1.
  - carry_r = sub; idx = 0; state goes to RUN.
- Start while in RUN is ignored. The in-flight operation completes unaffected.
- Each RUN edge:
  - slice inputs are a_r[idx*4+:4], b_r[idx*4+:4], carry_r.
  - slice sum is written into accumulator nibble idx; carry_r takes the slice cout; idx increments.
- On the RUN edge where idx = NSLICE-1:
  - Q <= {slice cout, full accumulator including this nibble}.
  - ovf <= (a_r[MSB] == b_r[MSB]) && (sum[MSB] != a_r[MSB]), where b_r is the already-inverted operand when sub=1.
  - state goes to DONE.
- DONE lasts exactly one cycle, then goes to IDLE, unless start is accepted on that edge, in which case it goes to RUN.
- Latency: start sampled at edge E gives busy high from E through E+NSLICE, Q/ovf updated at edge E+NSLICE, and done high between E+NSLICE and E+NSLICE+1. For WIDTH=16 that is 4 cycles.
- Q and ovf change only at the final RUN edge or at reset. They never show partial sums.
- Subtract carry semantics: Q[WIDTH]=1 means no borrow (A >= B unsigned).
- WIDTH=4: a single RUN cycle. Same rules apply.

Decomposition:
- Shared package:
  - state enum {IDLE, RUN, DONE}.
  - SLICE_W = 4 constant.
  - Helper function for slice count.
- One sub-module: rca_slice4. It is a purely combinational 4-bit ripple-carry slice with ports a[4], b[4], cin, s[4], cout, built from the existing full_adder cells.
- The controller instantiates it once.

Test Plan:
- Reset: hold rst_n=0, toggle clk, then pulse start=1 while reset is still low → Q=0, ovf=0, busy=0, done=0 throughout; start has no effect.
- Basic add, WIDTH=16: A=0x1234, B=0x4321, sub=0, start for 1 cycle at edge E → busy high E..E+4, done high exactly one cycle after E+4, Q=0x05555, ovf=0.
- Full carry ripple across slices: A=0xFFFF, B=0x0001, add → Q=0x10000, ovf=0. Then A=0x7FFF, B=0x0001 → Q=0x08000, ovf=1.
- Subtract with borrow: A=0x0005, B=0x0007, sub=1 → Q=0x0FFFE (carry 0 = borrow), ovf=0. Then A=0x8000, B=0x0001, sub=1 → Q=0x17FFF, ovf=1.
- Handshake edges:
  - start held high during RUN with different A/B → ignored; result matches the first operands.
  - start asserted in the DONE cycle with A=0x0001, B=0x0002 → goes directly to RUN; next done gives Q=0x00003.
- Reset mid-operation: assert rst_n=0 asynchronously between edges E+2 and E+3 → busy/Q/ovf drop to 0 immediately and no done occurs. After release, a new start (A=0x00FF, B=0x0001) produces Q=0x00100 at normal latency.
